axi_stream_fork_split: RTL and testbench
========================================

Name: axi_stream_fork_split

Overview:
- Splits one double-width AXI-stream into two independent width-wide streams: a carries the low half, b carries the high half.
- This is the counterpart of the sum join: where the join merges two input streams into one, this fork fans one input stream out to two consumers.
- Each input word is held in a holding register with per-branch done flags, so the two branches drain independently.
- Each branch has its own internal FIFO, so a stalled consumer never blocks the other branch until that branch's FIFO fills.

Parameters:
- width, 8, width of each output half; in_data is 2*width bits.
- depth, 10, entries per branch FIFO; any value >= 2, not restricted to a power of two.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  2*width  [width-1:0] goes to a, [2*width-1:width] goes to b.
- a_valid  output  1  branch a word valid.
- a_ready  input  1  branch a consumer ready.
- a_data  output  width  branch a word.
- b_valid  output  1  branch b word valid.
- b_ready  input  1  branch b consumer ready.
- b_data  output  width  branch b word.

Behaviour:
- Reset (rst high at a clock edge) clears: hold_valid, a_done, b_done, both FIFO read/write pointers, and both counts.
  - While rst is high: in_ready=0, a_valid=0, b_valid=0.
  - After rst is released: in_ready=1, and a_data/b_data contents are don't-care.
  - Reset mid-transfer discards the held word and all FIFO contents; there is no partial output.
- Handshake: a transfer happens on a cycle with valid&ready. valid must not depend on ready; data is stable while valid&!ready.
- Holding stage, with registers hold_data, hold_valid, a_done, b_done:
  - push_a = hold_valid & !a_done & (cnt_a < depth); push_b is the same with b.
  - release = hold_valid & (a_done|push_a) & (b_done|push_b).
  - in_ready = !rst & (!hold_valid | release). This is combinational, so back-to-back acceptance is one word per cycle.
  - On in_valid&in_ready: hold_data<=in_data, hold_valid<=1, a_done<=0, b_done<=0.
  - Else on release: hold_valid<=0, a_done<=0, b_done<=0.
  - Else: a_done<=a_done|push_a, b_done<=b_done|push_b.
  - The halves may be pushed on different cycles. Each half is pushed exactly once per accepted word.
- Branch FIFO, one per branch, identical:
  - Storage mem[depth]; pointers wrap from depth-1 to 0; count width is clog2(depth+1).
  - valid = (count != 0); data = mem[rd_ptr], read combinationally.
  - pop = valid & ready.
  - Push writes mem[wr_ptr]. Push when count == depth is never issued; there is no full-FIFO bypass.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - There is no empty-FIFO bypass: a word pushed at edge N is visible at the output after edge N.
- Latency: input accepted at edge N → pushed at edge N+1 → a_valid/b_valid high in the cycle after edge N+1. Minimum latency is 2 cycles.
- Ordering: each branch outputs words in acceptance order.
- Throughput: 1 word/cycle when both consumers are always ready.
- Capacity: up to depth words per branch, plus 1 word in the holding register. For example, with b stalled, depth+1 words are accepted before in_ready drops.
- Overflow: impossible by construction. Underflow: impossible, because pop requires valid.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid=1 → in_ready=a_valid=b_valid=0 throughout. The cycle after release → in_ready=1.
- Streaming, width=8: send 16'h0201, 16'h0403, 16'h0605 back-to-back with both consumers ready. Expect in_ready=1 every cycle; a sees 01,03,05 and b sees 02,04,06 on consecutive cycles; the first output appears 2 cycles after the first acceptance.
- Stalled branch, depth=10: hold b_ready=0 with a_ready=1 and send 20 words. Expect exactly 11 words accepted and then in_ready=0; a emits all 11; b_valid=1 with count 10. Then set b_ready=1: b drains all 11 in order and in_ready reasserts.
- Split push: b FIFO full and a FIFO with space; hold one word. Expect a_done=1 one cycle, with no duplicate on a. When b frees one entry, the b half is pushed and the word is released the same cycle.
- Wrap-around: random valid/ready at 50% duty for 1000 words with depth=10 (non-power-of-two). Expect the scoreboard to match per branch, no loss or duplication, and correct pointer wrap at 9→0.
- Mid-operation reset: with both FIFOs holding 5 words, pulse rst for 1 cycle. Expect valid=0 on both branches the next cycle, old data never emitted, and new words flow normally afterward.

Source files
------------

// File: rtl/axi_stream_fork_split.sv
// axi_stream_fork_split: fans one double-width stream out to two width-wide
// branches. The low half goes to a and the high half goes to b. A holding
// register with per-branch done flags lets each half be pushed into its own
// branch FIFO independently.

module axi_stream_fork_split_fifo #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  output logic                         valid,
  input  logic                         ready,
  output logic [width-1:0]             data,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int ptr_w = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             pop;

  // Pointers wrap at depth-1 so that depth need not be a power of two.
  function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Output side: the head entry is read combinationally and hidden during reset.
  always_comb begin
    valid = !rst && (count != '0);
    data  = mem[rd_ptr];
    pop   = valid && ready;
  end

  // Storage write. The caller never pushes into a full FIFO.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module axi_stream_fork_split #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*width-1:0] in_data,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [width-1:0]   a_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [width-1:0]   b_data
);

  localparam int cnt_w = $clog2(depth + 1);

  logic [2*width-1:0] hold_data;
  logic               hold_valid;
  logic               a_done;
  logic               b_done;
  logic               push_a;
  logic               push_b;
  logic               hold_release;
  logic [cnt_w-1:0]   cnt_a;
  logic [cnt_w-1:0]   cnt_b;

  // Each half is pushed once, whenever its FIFO has room; the word is released
  // on the cycle its last outstanding half goes in, so a new word can be taken
  // on that same cycle.
  always_comb begin
    push_a       = hold_valid && !a_done && (cnt_a < cnt_w'(depth));
    push_b       = hold_valid && !b_done && (cnt_b < cnt_w'(depth));
    hold_release = hold_valid && (a_done || push_a) && (b_done || push_b);
    in_ready     = !rst && (!hold_valid || hold_release);
  end

  // Holding register with per-branch done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_data  <= in_data;
      hold_valid <= 1'b1;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
    end else if (hold_release) begin
      hold_valid <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
    end else begin
      a_done <= a_done || push_a;
      b_done <= b_done || push_b;
    end
  end

  axi_stream_fork_split_fifo #(
    .width(width),
    .depth(depth)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (hold_data[width-1:0]),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data),
    .count     (cnt_a)
  );

  axi_stream_fork_split_fifo #(
    .width(width),
    .depth(depth)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (hold_data[2*width-1:width]),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data),
    .count     (cnt_b)
  );

endmodule

// File: tb/tb_axi_stream_fork_split.sv
// Testbench for axi_stream_fork_split (width=8, depth=10).
module tb_axi_stream_fork_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [7:0]  a_data;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [7:0]  b_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  typedef struct {
    logic [15:0] din;
    logic [7:0]  ea;
    logic [7:0]  eb;
  } vec_t;

  vec_t tbl[3];

  axi_stream_fork_split #(
    .width(8),
    .depth(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected halves recorded on acceptance, compared on each pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_a.push_back(in_data[7:0]);
        exp_b.push_back(in_data[15:8]);
      end
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) check("a_unexpected_pop", int'(a_data), -1);
        else check("a_data", int'(a_data), int'(exp_a.pop_front()));
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_pop", int'(b_data), -1);
        else check("b_data", int'(b_data), int'(exp_b.pop_front()));
      end
    end
  end

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", exp_a.size() + exp_b.size(), 0);
  endtask

  initial begin
    int accepted;
    int sent;
    int cyc;
    bit acc;

    tbl[0] = '{16'h0201, 8'h01, 8'h02};
    tbl[1] = '{16'h0403, 8'h03, 8'h04};
    tbl[2] = '{16'h0605, 8'h05, 8'h06};

    // Reset held with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(posedge clk);
      #1 in_valid = 1'b1;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_a_valid", int'(a_valid), 0);
      check("rst_b_valid", int'(b_valid), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    // Back-to-back streaming from the table, both consumers ready.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        in_valid = 1'b1;
        in_data  = tbl[k].din;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 3) check("stream_in_ready", int'(in_ready), 1);
      check("stream_a_valid", int'(a_valid), int'(k >= 2 && k < 5));
      check("stream_b_valid", int'(b_valid), int'(k >= 2 && k < 5));
      if (k >= 2 && k < 5) begin
        check("stream_a_tbl", int'(a_data), int'(tbl[k-2].ea));
        check("stream_b_tbl", int'(b_data), int'(tbl[k-2].eb));
      end
    end
    drain(20);

    // Branch b stalled: depth words in b's FIFO plus one held word.
    a_ready  = 1'b1;
    b_ready  = 1'b0;
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      in_valid = (accepted < 20);
      in_data  = {8'(8'h80 + accepted), 8'(accepted)};
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
    end
    check("stall_accepted", accepted, 11);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_b_valid", int'(b_valid), 1);
    check("stall_a_valid", int'(a_valid), 0);
    check("stall_a_pending", exp_a.size(), 0);
    check("stall_b_pending", exp_b.size(), 11);
    @(posedge clk);
    #1 in_valid = 1'b0;
    b_ready = 1'b1;
    drain(40);
    @(negedge clk);
    check("stall_in_ready_back", int'(in_ready), 1);
    check("stall_a_idle", int'(a_valid), 0);
    check("stall_b_idle", int'(b_valid), 0);

    // Random valid/ready traffic over many pointer wraps.
    sent = 0;
    cyc  = 0;
    @(posedge clk);
    #1;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 1) == 1) && (sent < 1000);
        in_data  = 16'($urandom);
      end
      a_ready = ($urandom_range(0, 1) == 1);
      b_ready = ($urandom_range(0, 1) == 1);
    end
    check("random_sent", sent, 1000);
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    drain(200);

    // Mid-operation reset with 5 words in each FIFO.
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20 && accepted < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = {8'(8'hE0 + accepted), 8'(8'hD0 + accepted)};
      @(negedge clk);
      if (in_ready) accepted++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_a_valid", int'(a_valid), 1);
    check("mid_b_valid", int'(b_valid), 1);
    check("mid_pending", exp_a.size(), 5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_a_valid", int'(a_valid), 0);
    check("mid_rst_b_valid", int'(b_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = {8'(8'h30 + k), 8'(8'h20 + k)};
      @(negedge clk);
      check("mid_new_in_ready", int'(in_ready), 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain(20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_a_idle", int'(a_valid), 0);
    check("final_b_idle", int'(b_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
